command_sink: RTL and testbench

COMMAND_SINK -- requirements
Module: command_sink

---
 rtl/command_pkg.sv | 25 ++
 rtl/strobe_qual.sv | 78 +++++++
 rtl/command_sink.sv | 100 ++++++++++
 tb/tb_command_sink.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_pkg.sv
// Shared types and constants for the command sink: qualifier states and
// register-file geometry.
package command_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FIRE,
    WAIT_LOW
  } qual_state_t;

  localparam int NREG     = 16;
  localparam int IDX_W    = $clog2(NREG);
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int DATA32_W = 32;

  // Lowest address that falls outside the register file.
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NREG);

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_LIMIT;
  endfunction

endpackage

// File: rtl/strobe_qual.sv
// Strobe qualifier: a strobe must be high for MIN_HIGH consecutive cycles
// to produce one accept pulse; a strobe that drops early flags short_err.
module strobe_qual
  import command_pkg::*;
#(
  parameter int MIN_HIGH = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic accept,
  output logic short_err
);

  // MIN_HIGH must be at least 1.
  localparam int CW = $clog2(MIN_HIGH + 1);
  localparam logic [CW-1:0] TARGET = CW'(MIN_HIGH);
  localparam logic [CW-1:0] ONE    = CW'(1);

  qual_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter holds the number of high samples seen in the current run.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    short_err  = 1'b0;
    case (state)
      IDLE: begin
        if (strobe) begin
          cnt_next   = ONE;
          state_next = (ONE == TARGET) ? FIRE : COUNT;
        end
      end
      COUNT: begin
        if (strobe) begin
          cnt_next = cnt_inc;
          if (cnt_inc == TARGET) begin
            state_next = FIRE;
          end
        end else begin
          cnt_next   = '0;
          short_err  = 1'b1;
          state_next = IDLE;
        end
      end
      FIRE: begin
        accept     = 1'b1;
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!strobe) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/command_sink.sv
// Command sink: two qualified write strobes feeding a 16x8 register file and
// a 32-bit register, with sticky error flags for bad addresses and short strobes.
module command_sink
  import command_pkg::*;
#(
  parameter int CLK_FREQ = 200000000,
  parameter int MIN_HIGH = CLK_FREQ / 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_cmd,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                sw_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                sw_in32,
  input  logic [DATA32_W-1:0] data_in32,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [DATA32_W-1:0] reg32,
  output logic                wr_pulse,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic                wr_pulse32,
  output logic                err_addr,
  output logic                err_short
);

  logic accept8, accept32;
  logic short8, short32;
  logic addr_ok;
  logic wr8_go, wr32_go;

  logic [DATA_W-1:0] regs [NREG];

  strobe_qual #(.MIN_HIGH(MIN_HIGH)) u_qual8 (
    .clk       (clk),
    .reset     (reset),
    .strobe    (sw_in),
    .accept    (accept8),
    .short_err (short8)
  );

  strobe_qual #(.MIN_HIGH(MIN_HIGH)) u_qual32 (
    .clk       (clk),
    .reset     (reset),
    .strobe    (sw_in32),
    .accept    (accept32),
    .short_err (short32)
  );

  // A register clear on the accept edge drops the write and its pulse.
  assign addr_ok = addr_in_range(addr);
  assign wr8_go  = accept8 && addr_ok && !reset_cmd;
  assign wr32_go = accept32 && !reset_cmd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      reg32   <= '0;
      wr_addr <= '0;
    end else if (reset_cmd) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      reg32   <= '0;
      wr_addr <= '0;
    end else begin
      if (wr8_go) begin
        regs[addr[IDX_W-1:0]] <= data_in;
        wr_addr               <= addr;
      end
      if (wr32_go) begin
        reg32 <= data_in32;
      end
    end
  end

  // Pulses and sticky flags ignore reset_cmd apart from the dropped write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_pulse   <= 1'b0;
      wr_pulse32 <= 1'b0;
      err_addr   <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      wr_pulse   <= wr8_go;
      wr_pulse32 <= wr32_go;
      if (accept8 && !addr_ok) begin
        err_addr <= 1'b1;
      end
      if (short8 || short32) begin
        err_short <= 1'b1;
      end
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_command_sink.sv
// Self-checking bench for command_sink: directed vector table, hand-built
// reset/clear sequences, and randomized strobes against a run-length model.
module tb_command_sink;
  import command_pkg::*;

  localparam int MIN_HIGH = 40;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        reset_cmd = 1'b0;
  logic [7:0]  addr      = '0;
  logic        sw_in     = 1'b0;
  logic [7:0]  data_in   = '0;
  logic        sw_in32   = 1'b0;
  logic [31:0] data_in32 = '0;
  logic [3:0]  rd_addr   = '0;
  logic [7:0]  rd_data;
  logic [31:0] reg32;
  logic        wr_pulse;
  logic [7:0]  wr_addr;
  logic        wr_pulse32;
  logic        err_addr;
  logic        err_short;

  always #5 clk = ~clk;

  command_sink #(.CLK_FREQ(200000000), .MIN_HIGH(MIN_HIGH)) dut (
    .clk        (clk),
    .reset      (reset),
    .reset_cmd  (reset_cmd),
    .addr       (addr),
    .sw_in      (sw_in),
    .data_in    (data_in),
    .sw_in32    (sw_in32),
    .data_in32  (data_in32),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .reg32      (reg32),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_pulse32 (wr_pulse32),
    .err_addr   (err_addr),
    .err_short  (err_short)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: counts consecutive high samples per strobe; a run
  // reaching MIN_HIGH schedules one write for the following edge.
  logic [7:0]  m_regs [16];
  logic [31:0] m_reg32;
  logic [7:0]  m_wr_addr;
  logic        m_wr_pulse, m_wr_pulse32, m_err_addr, m_err_short;
  int          run8, run32;
  bit          pend8, pend32;

  int edge_no, p8, p32, first8, first32, both;

  typedef struct {
    int          len8;
    int          len32;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] data32;
    int          exp_p8;
    int          exp_p32;
    int          exp_edge8;
    int          exp_edge32;
    int          exp_both;
    logic [7:0]  exp_rd;
    logic [31:0] exp_reg32;
    logic [7:0]  exp_wr_addr;
    logic        exp_err_addr;
    logic        exp_err_short;
  } vec_t;

  vec_t vecs [12];

  task automatic model_step();
    if (!reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_reg32 = '0; m_wr_addr = '0;
      m_wr_pulse = 0; m_wr_pulse32 = 0; m_err_addr = 0; m_err_short = 0;
      run8 = 0; run32 = 0; pend8 = 0; pend32 = 0;
    end else begin
      m_wr_pulse = 0;
      m_wr_pulse32 = 0;
      if (pend8 && addr >= 8'd16) m_err_addr = 1;
      if (reset_cmd) begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_reg32 = '0;
        m_wr_addr = '0;
      end else begin
        if (pend8 && addr < 8'd16) begin
          m_regs[addr[3:0]] = data_in;
          m_wr_addr = addr;
          m_wr_pulse = 1;
        end
        if (pend32) begin
          m_reg32 = data_in32;
          m_wr_pulse32 = 1;
        end
      end
      pend8 = 0;
      pend32 = 0;
      if (sw_in) begin
        run8++;
        if (run8 == MIN_HIGH) pend8 = 1;
      end else begin
        if (run8 > 0 && run8 < MIN_HIGH) m_err_short = 1;
        run8 = 0;
      end
      if (sw_in32) begin
        run32++;
        if (run32 == MIN_HIGH) pend32 = 1;
      end else begin
        if (run32 > 0 && run32 < MIN_HIGH) m_err_short = 1;
        run32 = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    edge_no++;
    if (wr_pulse) begin
      p8++;
      if (first8 == 0) first8 = edge_no;
    end
    if (wr_pulse32) begin
      p32++;
      if (first32 == 0) first32 = edge_no;
    end
    if (wr_pulse && wr_pulse32) both++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clear_counts();
    edge_no = 0; p8 = 0; p32 = 0; first8 = 0; first32 = 0; both = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; reset_cmd = 1'b0; sw_in = 1'b0; sw_in32 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    clear_counts();
  endtask

  task automatic applyStimulus(input vec_t v);
    int last;
    do_reset();
    addr = v.addr; data_in = v.data; data_in32 = v.data32; rd_addr = v.addr[3:0];
    last = ((v.len8 > v.len32) ? v.len8 : v.len32) + 8;
    for (int e = 1; e <= last; e++) begin
      sw_in   = (e <= v.len8);
      sw_in32 = (e <= v.len32);
      tick();
    end
  endtask

  function automatic int pick_len();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(1, MIN_HIGH - 2);
      1:       return MIN_HIGH - 1;
      2, 5:    return MIN_HIGH;
      3:       return MIN_HIGH + 1;
      default: return $urandom_range(MIN_HIGH + 2, 90);
    endcase
  endfunction

  initial begin
    int hi8, lo8, hi32, lo32;

    vecs[0]  = '{80,  0,  8'h05, 8'hA5, 32'h0,        1, 0, 41, 0,  0, 8'hA5, 32'h0,        8'h05, 1'b0, 1'b0};
    vecs[1]  = '{39,  0,  8'h03, 8'h11, 32'h0,        0, 0, 0,  0,  0, 8'h00, 32'h0,        8'h00, 1'b0, 1'b1};
    vecs[2]  = '{40,  0,  8'h03, 8'h11, 32'h0,        1, 0, 41, 0,  0, 8'h11, 32'h0,        8'h03, 1'b0, 1'b0};
    vecs[3]  = '{41,  0,  8'h0F, 8'h7E, 32'h0,        1, 0, 41, 0,  0, 8'h7E, 32'h0,        8'h0F, 1'b0, 1'b0};
    vecs[4]  = '{80,  0,  8'h20, 8'h55, 32'h0,        0, 0, 0,  0,  0, 8'h00, 32'h0,        8'h00, 1'b1, 1'b0};
    vecs[5]  = '{80,  0,  8'h10, 8'h66, 32'h0,        0, 0, 0,  0,  0, 8'h00, 32'h0,        8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1,   0,  8'h07, 8'h12, 32'h0,        0, 0, 0,  0,  0, 8'h00, 32'h0,        8'h00, 1'b0, 1'b1};
    vecs[7]  = '{80,  80, 8'h0A, 8'hC3, 32'hDEADBEEF, 1, 1, 41, 41, 1, 8'hC3, 32'hDEADBEEF, 8'h0A, 1'b0, 1'b0};
    vecs[8]  = '{0,   39, 8'h00, 8'h00, 32'h12345678, 0, 0, 0,  0,  0, 8'h00, 32'h0,        8'h00, 1'b0, 1'b1};
    vecs[9]  = '{500, 0,  8'h0C, 8'h3C, 32'h0,        1, 0, 41, 0,  0, 8'h3C, 32'h0,        8'h0C, 1'b0, 1'b0};
    vecs[10] = '{0,   40, 8'h00, 8'h00, 32'hCAFEF00D, 0, 1, 0,  41, 0, 8'h00, 32'hCAFEF00D, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{2,   45, 8'h01, 8'h01, 32'h000000FF, 0, 1, 0,  41, 0, 8'h00, 32'h000000FF, 8'h00, 1'b0, 1'b1};

    // Reset state
    do_reset();
    checkOutput("rst.reg32", reg32, 32'h0);
    checkOutput("rst.wr_addr", 32'(wr_addr), 32'h0);
    checkOutput("rst.wr_pulse", 32'(wr_pulse), 32'h0);
    checkOutput("rst.wr_pulse32", 32'(wr_pulse32), 32'h0);
    checkOutput("rst.err_addr", 32'(err_addr), 32'h0);
    checkOutput("rst.err_short", 32'(err_short), 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checkOutput($sformatf("rst.rd_data[%0d]", i), 32'(rd_data), 32'h0);
    end

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d.pulses8", i), 32'(p8), 32'(vecs[i].exp_p8));
      checkOutput($sformatf("vec%0d.pulses32", i), 32'(p32), 32'(vecs[i].exp_p32));
      checkOutput($sformatf("vec%0d.edge8", i), 32'(first8), 32'(vecs[i].exp_edge8));
      checkOutput($sformatf("vec%0d.edge32", i), 32'(first32), 32'(vecs[i].exp_edge32));
      checkOutput($sformatf("vec%0d.both", i), 32'(both), 32'(vecs[i].exp_both));
      checkOutput($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
      checkOutput($sformatf("vec%0d.reg32", i), reg32, vecs[i].exp_reg32);
      checkOutput($sformatf("vec%0d.wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_wr_addr));
      checkOutput($sformatf("vec%0d.err_addr", i), 32'(err_addr), 32'(vecs[i].exp_err_addr));
      checkOutput($sformatf("vec%0d.err_short", i), 32'(err_short), 32'(vecs[i].exp_err_short));
    end

    // Short strobe, then a qualifying one with no reset in between
    do_reset();
    addr = 8'h04; data_in = 8'h44; rd_addr = 4'h4;
    for (int e = 1; e <= 100; e++) begin
      sw_in = (e <= 39) || (e >= 43 && e <= 82);
      tick();
    end
    checkOutput("short_then_ok.pulses8", 32'(p8), 32'd1);
    checkOutput("short_then_ok.edge8", 32'(first8), 32'd83);
    checkOutput("short_then_ok.rd_data", 32'(rd_data), 32'h44);
    checkOutput("short_then_ok.err_short", 32'(err_short), 32'h1);

    // reset_cmd on the accept edge clears everything and drops the write
    do_reset();
    addr = 8'h02; data_in = 8'h33; data_in32 = 32'h11223344; rd_addr = 4'h2;
    for (int e = 1; e <= 50; e++) begin
      sw_in   = (e <= 40);
      sw_in32 = (e <= 40) || (e >= 45 && e <= 49);
      tick();
    end
    checkOutput("clr.pre_rd_data", 32'(rd_data), 32'h33);
    checkOutput("clr.pre_reg32", reg32, 32'h11223344);
    checkOutput("clr.pre_err_short", 32'(err_short), 32'h1);
    clear_counts();
    addr = 8'h05; data_in = 8'h99; data_in32 = 32'hAABBCCDD;
    sw_in = 1'b1; sw_in32 = 1'b1;
    for (int e = 1; e <= 500; e++) begin
      reset_cmd = (e == 41);
      tick();
    end
    reset_cmd = 1'b0;
    checkOutput("clr.pulses8", 32'(p8), 32'd0);
    checkOutput("clr.pulses32", 32'(p32), 32'd0);
    checkOutput("clr.rd_data2", 32'(rd_data), 32'h0);
    rd_addr = 4'h5;
    #1;
    checkOutput("clr.rd_data5", 32'(rd_data), 32'h0);
    checkOutput("clr.reg32", reg32, 32'h0);
    checkOutput("clr.wr_addr", 32'(wr_addr), 32'h0);
    checkOutput("clr.err_short_kept", 32'(err_short), 32'h1);
    sw_in = 1'b0; sw_in32 = 1'b0;
    tick();

    // Reset low mid-count restarts qualification
    do_reset();
    addr = 8'h09; data_in = 8'h5A; rd_addr = 4'h9;
    for (int e = 1; e <= 8; e++) begin
      sw_in = (e <= 3);
      tick();
    end
    checkOutput("midrst.pre_err_short", 32'(err_short), 32'h1);
    clear_counts();
    for (int e = 1; e <= 80; e++) begin
      sw_in = (e <= 70);
      reset = !(e >= 20 && e <= 24);
      tick();
    end
    reset = 1'b1;
    checkOutput("midrst.pulses8", 32'(p8), 32'd1);
    checkOutput("midrst.edge8", 32'(first8), 32'd65);
    checkOutput("midrst.rd_data", 32'(rd_data), 32'h5A);
    checkOutput("midrst.wr_addr", 32'(wr_addr), 32'h09);
    checkOutput("midrst.err_short", 32'(err_short), 32'h0);

    // Randomized traffic against the run-length model
    do_reset();
    hi8 = 0; lo8 = 0; hi32 = 0; lo32 = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hi8 == 0 && lo8 == 0) begin
        hi8 = pick_len();
        lo8 = $urandom_range(2, 6);
      end
      if (hi8 > 0) begin sw_in = 1'b1; hi8--; end
      else begin sw_in = 1'b0; lo8--; end
      if (hi32 == 0 && lo32 == 0) begin
        hi32 = pick_len();
        lo32 = $urandom_range(2, 6);
      end
      if (hi32 > 0) begin sw_in32 = 1'b1; hi32--; end
      else begin sw_in32 = 1'b0; lo32--; end
      addr      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                              : 8'($urandom_range(0, 15));
      data_in   = 8'($urandom);
      data_in32 = 32'($urandom);
      rd_addr   = 4'($urandom_range(0, 15));
      reset_cmd = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 599) != 0);
      tick();
      checkOutput("rand.wr_pulse", 32'(wr_pulse), 32'(m_wr_pulse));
      checkOutput("rand.wr_pulse32", 32'(wr_pulse32), 32'(m_wr_pulse32));
      checkOutput("rand.err_addr", 32'(err_addr), 32'(m_err_addr));
      checkOutput("rand.err_short", 32'(err_short), 32'(m_err_short));
      checkOutput("rand.wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      checkOutput("rand.reg32", reg32, m_reg32);
      checkOutput("rand.rd_data", 32'(rd_data), 32'(m_regs[rd_addr]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
